iter_divider: RTL and testbench

Multi-cycle RV32M divide/remainder unit: the subtractive counterpart to the single-cycle `adder`, implemented as a radix-2 restoring divider that retires one quotient bit per clock. It sits beside the ALU in the execute stage. The hazard unit stalls the pipeline while `busy` is high and captures `result` on the single-cycle `done` pulse. It covers DIV, DIVU, REM and REMU with the RISC-V-mandated results for divide-by-zero and signed overflow.

---
 rtl/iter_divider.sv | 194 +++++++++++++++++++
 tb/tb_iter_divider.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
`timescale 1ns/1ps
// Radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock; optional DIV_EARLY_OUT_EN.
// Latency: 34 cycles from start to done (2 cycles for b=0 / signed overflow when DIV_EARLY_OUT_EN is defined).
// No backpressure: start is taken only in IDLE, ignored while busy; kill aborts to IDLE on the next edge.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Iteration state
  logic [WIDTH-1:0] dvs;   // |divisor|
  logic [WIDTH-1:0] rem;   // partial remainder
  logic [WIDTH-1:0] quo;   // dividend bits shifting out, quotient bits shifting in
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;

  // Decoded operation and helpers
  logic             is_signed;
  logic             is_rem;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             accept;
  logic             fix_fire;

  // Operand conditioning, trial subtraction and final sign fix-up
  always_comb begin
    is_signed = ~op_q[0];
    is_rem    = op_q[1];
    a_abs     = (is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    b_abs     = (is_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
    b_zero    = (b_q == '0);
    ovf       = is_signed && (a_q == MIN_NEG) && (b_q == '1);
    rem_sh    = {rem, quo[WIDTH-1]};
    trial     = rem_sh - {1'b0, dvs};
    trial_ok  = ~trial[WIDTH];
    // Divide-by-zero is forced here so the signed path cannot flip the all-ones quotient.
    if (b_zero) begin
      q_fix = '1;
      r_fix = a_q;
    end else begin
      q_fix = q_neg ? (~quo + 1'b1) : quo;
      r_fix = r_neg ? (~rem + 1'b1) : rem;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs; kill overrides everything
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    accept    = 1'b0;
    fix_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_PREP;
        end
      end
      S_PREP: begin
`ifdef DIV_EARLY_OUT_EN
        state_nxt = (b_zero || ovf) ? S_FIX : S_ITER;
`else
        state_nxt = S_ITER;
`endif
      end
      S_ITER: begin
        if (cnt == '0) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        fix_fire  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (kill) begin
      accept    = 1'b0;
      fix_fire  = 1'b0;
      state_nxt = S_IDLE;
    end
  end

  // Request capture and the shift/subtract datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (state == S_PREP) begin
        dvs   <= b_abs;
        quo   <= a_abs;
        rem   <= '0;
        cnt   <= CW'(WIDTH - 1);
        q_neg <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg <= is_signed & a_q[WIDTH-1];
`ifdef DIV_EARLY_OUT_EN
        // Preload the architectural answers so FIX can emit them directly.
        if (b_zero) begin
          quo   <= '1;
          rem   <= a_q;
          q_neg <= 1'b0;
          r_neg <= 1'b0;
        end else if (ovf) begin
          quo   <= MIN_NEG;
          rem   <= '0;
          q_neg <= 1'b0;
          r_neg <= 1'b0;
        end
`endif
      end
      if (state == S_ITER) begin
        if (trial_ok) begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Result register and single-cycle done pulse; a killed FIX leaves result untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= fix_fire;
      if (fix_fire) begin
        result <= is_rem ? r_fix : q_fix;
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
`timescale 1ns/1ps
// Directed and random bench for iter_divider with a scoreboard queue of expected results.
// Checks result values, start-to-done latency, busy/done framing, kill, reset and back-to-back issue.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge.
module tb_iter_divider;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  iter_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    if (y == 32'h0) begin
      r = o[1] ? x : 32'hFFFF_FFFF;
    end else if (!o[0]) begin
      if (x == MIN_NEG && y == 32'hFFFF_FFFF) r = o[1] ? 32'h0 : MIN_NEG;
      else if (o[1]) r = $signed(x) % $signed(y);
      else r = $signed(x) / $signed(y);
    end else begin
      r = o[1] ? (x % y) : (x / y);
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int l;
    l = 34;
`ifdef DIV_EARLY_OUT_EN
    if (y == 32'h0 || (!o[0] && x == MIN_NEG && y == 32'hFFFF_FFFF)) l = 2;
`endif
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after edge 0.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_q.push_back(model_result(o, x, y));
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts at the falling edge after edge e0; stops on the falling edge where done is seen.
  task automatic wait_done(input int e0, output int edges, output bit ok, output bit busy_ok);
    edges = e0; ok = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input string tag, input int edges, input bit ok, input bit busy_ok, input int lat);
    logic [31:0] expv;
    expv = exp_q.pop_front();
    check({tag, "_done_seen"}, {31'b0, ok}, 32'd1);
    if (ok) begin
      check({tag, "_latency"}, 32'(edges), 32'(lat));
      check({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
      check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      check({tag, "_result"}, result, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int edges; bit ok; bit busy_ok; logic [31:0] held;
    issue(o, x, y);
    wait_done(0, edges, ok, busy_ok);
    finish_op(tag, edges, ok, busy_ok, model_lat(o, x, y));
    held = result;
    @(negedge clk);
    check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
    check({tag, "_result_hold"}, result, held);
  endtask

  initial begin
    int edges; bit ok; bit busy_ok; bit saw_done;
    int t1; int t2;
    logic [31:0] prev;
    logic [1:0] ro; logic [31:0] ra; logic [31:0] rb;

    reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic, signed, divide-by-zero and overflow cases
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    check("divu_100_7_const", result, 32'd14);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
    check("remu_100_7_const", result, 32'd2);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_const", result, 32'hFFFF_FFFD);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2_const", result, 32'hFFFF_FFFF);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2_const", result, 32'hFFFF_FFFD);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE);
    check("rem_7_m2_const", result, 32'd1);
    run_op("div_by0", OP_DIV, 32'h1234_5678, 32'd0);
    check("div_by0_const", result, 32'hFFFF_FFFF);
    run_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0);
    check("divu_by0_const", result, 32'hFFFF_FFFF);
    run_op("rem_by0", OP_REM, 32'h1234_5678, 32'd0);
    check("rem_by0_const", result, 32'h1234_5678);
    run_op("remu_by0", OP_REMU, 32'h1234_5678, 32'd0);
    check("remu_by0_const", result, 32'h1234_5678);
    run_op("div_neg_by0", OP_DIV, 32'hF000_0001, 32'd0);
    run_op("rem_neg_by0", OP_REM, 32'hF000_0001, 32'd0);
    run_op("div_ovf", OP_DIV, MIN_NEG, 32'hFFFF_FFFF);
    check("div_ovf_const", result, MIN_NEG);
    run_op("rem_ovf", OP_REM, MIN_NEG, 32'hFFFF_FFFF);
    check("rem_ovf_const", result, 32'd0);
    run_op("divu_ovf", OP_DIVU, MIN_NEG, 32'hFFFF_FFFF);
    check("divu_ovf_const", result, 32'd0);
    run_op("remu_ovf", OP_REMU, MIN_NEG, 32'hFFFF_FFFF);
    check("remu_ovf_const", result, MIN_NEG);

    // start while busy is ignored
    issue(OP_DIVU, 32'd1000, 32'd10);
    repeat (5) @(negedge clk);
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'd1; op = OP_REMU;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, edges, ok, busy_ok);
    finish_op("mid_start", edges, ok, busy_ok, 34);
    @(negedge clk);
    check("mid_start_no_queue", {31'b0, busy}, 32'd0);

    // kill mid-run: no done, result held
    prev = result;
    issue(OP_DIVU, 32'd5000, 32'd7);
    void'(exp_q.pop_back());
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("kill_no_done", {31'b0, saw_done}, 32'd0);
    check("kill_result_hold", result, prev);
    run_op("after_kill_9_3", OP_DIVU, 32'd9, 32'd3);
    check("after_kill_const", result, 32'd3);

    // kill together with start in IDLE
    prev = result;
    start = 1'b1; kill = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", {31'b0, busy}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("kill_start_no_done", {31'b0, saw_done}, 32'd0);
    check("kill_start_result", result, prev);

    // asynchronous reset mid-ITER
    issue(OP_DIVU, 32'd77, 32'd5);
    void'(exp_q.pop_back());
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // back-to-back: second start presented in the done cycle
    issue(OP_DIVU, 32'd10, 32'd3);
    wait_done(0, edges, ok, busy_ok);
    t1 = cyc;
    finish_op("b2b_first", edges, ok, busy_ok, 34);
    check("b2b_first_const", result, 32'd3);
    issue(OP_DIVU, 32'd20, 32'd4);
    check("b2b_accept_busy", {31'b0, busy}, 32'd1);
    wait_done(0, edges, ok, busy_ok);
    t2 = cyc;
    finish_op("b2b_second", edges, ok, busy_ok, 34);
    check("b2b_second_const", result, 32'd5);
    check("b2b_spacing", 32'(t2 - t1), 32'd35);
    @(negedge clk);

    // random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 4 == 1) rb = ~rb + 32'd1;
      run_op("rand", ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
